// File: rtl/ahb_slave_ram_pkg.sv
// ahb_slave_ram: shared AHB types, response codes and slave state encoding.
// Optional feature macro: AHB_SLV_ERROR_EN (two-cycle ERROR on illegal transfers).
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [1:0] {
    HR_OKAY  = 2'd0,
    HR_ERROR = 2'd1,
    HR_RETRY = 2'd2,
    HR_SPLIT = 2'd3
  } hresp_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } slv_state_t;

endpackage

// File: rtl/ahb_slave_ram_if.sv
// ahb_slave_ram: AHB bus bundle between one master and one slave.
// Optional feature macro: AHB_SLV_ERROR_EN (affects only the slave).
interface ahb_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS,
    output HSIZE, HBURST, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS,
    input  HSIZE, HBURST, HWDATA,
    output HREADY, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_slave_ram_array.sv
// ahb_slave_ram: word RAM, one synchronous write port and one
// enable-gated registered read port; contents are never reset.
module ahb_ram_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  assign o_rdata = r_rdata;

  // Write port and read register; the read word holds until the next read.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/ahb_slave_ram.sv
// ahb_slave_ram: AHB slave with decoded window, wait states and RAW forwarding.
// Optional feature macro: AHB_SLV_ERROR_EN (ERROR response for illegal transfers).
module ahb_slave_ram
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 0
) (
  input logic HCLK,
  input logic HRESET,
  ahb_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0] WS_M1 =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slv_state_t  r_state;
  logic [3:0]  r_cnt;
  logic        r_hready;
  hresp_t      r_hresp;
  logic        r_write;
  logic        r_legal;
  logic [AW-1:0] r_idx;
  logic        r_rzero;
  logic        r_fwd;
  logic [31:0] r_fwd_data;

  logic [32:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_legal;
  logic          w_accept;
  logic          w_we;
  logic          w_re;
  logic          w_fwd;
  logic [31:0]   w_ram_rdata;

  // Borrow in bit 32 flags an address below the window.
  assign w_off = {1'b0, bus.HADDR} - {1'b0, BASE_ADDR};
  assign w_idx = w_off[AW+1:2];
  assign w_legal = (bus.HSIZE == HSIZE_WORD)
                 && (bus.HADDR[1:0] == 2'b00)
                 && !w_off[32]
                 && (w_off < SPAN);

  assign w_accept = bus.HSEL & r_hready & bus.HTRANS[1];
  assign w_we = HRESET & (r_state == S_DATA)
              & r_write & r_legal;
  assign w_re = HRESET & w_accept
              & ~bus.HWRITE & w_legal;
  assign w_fwd = w_we & (r_idx == w_idx);

  assign bus.HREADY = r_hready;
  assign bus.HRESP  = r_hresp;
  assign bus.HRDATA = r_rzero ? 32'h0 :
                      r_fwd   ? r_fwd_data :
                                w_ram_rdata;

  ahb_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .i_clk   (HCLK),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (bus.HWDATA),
    .i_re    (w_re),
    .i_raddr (w_idx),
    .o_rdata (w_ram_rdata)
  );

  // Transfer FSM: captures address phases and sequences the data phase.
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_hready <= 1'b1;
      r_hresp  <= HR_OKAY;
      r_rzero  <= 1'b1;
      r_fwd    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= bus.HWRITE;
        r_legal <= w_legal;
        r_idx   <= w_idx;
        if (!bus.HWRITE) begin
          r_rzero    <= !w_legal;
          r_fwd      <= w_fwd;
          r_fwd_data <= bus.HWDATA;
        end
      end
      unique case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state  <= S_DATA;
            r_hready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
`ifdef AHB_SLV_ERROR_EN
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
        end
`endif
        default: begin
          r_state  <= S_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= HR_OKAY;
          if (w_accept) begin
`ifdef AHB_SLV_ERROR_EN
            if (!w_legal) begin
              r_state  <= S_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= HR_ERROR;
            end else
`endif
            if (WAIT_STATES == 0) begin
              r_state <= S_DATA;
            end else begin
              r_state  <= S_WAIT;
              r_hready <= 1'b0;
              r_cnt    <= WS_M1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_ram.sv
// tb_ahb_slave_ram: random and directed AHB traffic against a memory model.
// Optional feature macro: AHB_SLV_ERROR_EN selects the expected illegal response.
module tb_ahb_slave_ram;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int DEPTH = 256;
`ifdef AHB_SLV_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] wdata;
  } xfer_t;

  logic HCLK = 1'b0;
  logic HRESET = 1'b0;
  logic g_dut = 1'b0;

  logic        m_sel = 1'b0;
  logic [1:0]  m_trans = 2'd0;
  logic        m_wr = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [2:0]  m_size = 3'b010;
  logic [2:0]  m_burst = 3'b000;
  logic [31:0] m_wdata = 32'h0;

  int n_tests = 0;
  int n_fail = 0;
  int lo_cnt = 0;
  int last_dc = 0;
  logic [1:0]  last_rsp;
  logic [31:0] last_rd;
  logic [31:0] rd_log [$];
  logic [31:0] mem [2][DEPTH];
  xfer_t q [$];

  always #5 HCLK = ~HCLK;

  ahb_if a0 ();
  ahb_if a3 ();

  assign a0.HSEL   = m_sel & ~g_dut;
  assign a3.HSEL   = m_sel & g_dut;
  assign a0.HADDR  = m_addr;
  assign a3.HADDR  = m_addr;
  assign a0.HWRITE = m_wr;
  assign a3.HWRITE = m_wr;
  assign a0.HTRANS = m_trans;
  assign a3.HTRANS = m_trans;
  assign a0.HSIZE  = m_size;
  assign a3.HSIZE  = m_size;
  assign a0.HBURST = m_burst;
  assign a3.HBURST = m_burst;
  assign a0.HWDATA = m_wdata;
  assign a3.HWDATA = m_wdata;

  logic        w_rdy;
  logic [1:0]  w_rsp;
  logic [31:0] w_rd;
  assign w_rdy = g_dut ? a3.HREADY : a0.HREADY;
  assign w_rsp = g_dut ? a3.HRESP  : a0.HRESP;
  assign w_rd  = g_dut ? a3.HRDATA : a0.HRDATA;

  ahb_slave_ram #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (0)
  ) u_dut0 (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (a0)
  );

  ahb_slave_ram #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (3)
  ) u_dut3 (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (a3)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic xfer_t mk(input logic wr,
                               input logic [31:0] addr,
                               input logic [2:0] size,
                               input logic [31:0] wdata,
                               input logic [1:0] tr);
    xfer_t x;
    x.sel = 1'b1;
    x.tr = tr;
    x.wr = wr;
    x.addr = addr;
    x.size = size;
    x.burst = 3'b000;
    x.wdata = wdata;
    return x;
  endfunction

  function automatic bit is_legal(input xfer_t x);
    return (x.size == 3'b010) && (x.addr[1:0] == 2'b00)
        && (x.addr >= BASE) && (x.addr < BASE + 4 * DEPTH);
  endfunction

  task automatic complete(input xfer_t x, input int dc,
                          input logic [1:0] rsp,
                          input logic [31:0] rd);
    bit lg;
    bit er;
    int ws;
    int idx;
    lg = is_legal(x);
    er = ERR_EN && !lg;
    ws = g_dut ? 3 : 0;
    idx = int'((x.addr - BASE) >> 2);
    check("dp_cycles", dc, er ? 2 : ws + 1);
    check("dp_resp", rsp, er ? 1 : 0);
    if (!x.wr) begin
      check("rdata", rd, lg ? mem[g_dut][idx] : 32'h0);
      rd_log.push_back(rd);
    end else if (lg) begin
      mem[g_dut][idx] = x.wdata;
    end
    last_dc = dc;
    last_rsp = rsp;
    last_rd = rd;
  endtask

  task automatic drive_idle();
    m_sel = 1'b0;
    m_trans = 2'd0;
    m_wr = 1'b0;
  endtask

  task automatic run_seq();
    int ai = 0;
    bit dv = 1'b0;
    int dc = 0;
    int cyc = 0;
    xfer_t dp;
    logic rdy;
    logic [1:0] rsp;
    logic [31:0] rd;
    while ((ai < q.size() || dv) && cyc < 20000) begin
      cyc++;
      if (ai < q.size()) begin
        m_sel = q[ai].sel;
        m_trans = q[ai].tr;
        m_wr = q[ai].wr;
        m_addr = q[ai].addr;
        m_size = q[ai].size;
        m_burst = q[ai].burst;
      end else begin
        drive_idle();
      end
      m_wdata = (dv && dp.wr) ? dp.wdata : $urandom;
      @(negedge HCLK);
      rdy = w_rdy;
      rsp = w_rsp;
      rd = w_rd;
      if (!rdy) lo_cnt++;
      if (dv) begin
        dc++;
        if (rdy) begin
          complete(dp, dc, rsp, rd);
          dv = 1'b0;
        end else begin
          check("wait_resp", rsp,
                (ERR_EN && !is_legal(dp)) ? 1 : 0);
        end
      end else if (!rdy) begin
        check("idle_ready", rdy, 1);
      end
      if (rdy && ai < q.size()) begin
        if (q[ai].sel && q[ai].tr[1]) begin
          dp = q[ai];
          dv = 1'b1;
          dc = 0;
        end
        ai++;
      end
      @(posedge HCLK);
      #1;
    end
    if (ai < q.size() || dv) begin
      n_tests++;
      n_fail++;
      $display("FAIL seq_timeout ai=%0d dv=%0d", ai, dv);
    end
    drive_idle();
    q.delete();
  endtask

  task automatic illegal_set();
    xfer_t x;
    q.push_back(mk(1, BASE + 4 * DEPTH, 3'b010, 32'hBAD0_0001, 2));
    q.push_back(mk(0, BASE + 4 * DEPTH, 3'b010, 32'h0, 2));
    q.push_back(mk(1, BASE + 32'h2, 3'b010, 32'hBAD0_0002, 2));
    q.push_back(mk(0, BASE + 32'h2, 3'b010, 32'h0, 2));
    q.push_back(mk(0, BASE, 3'b010, 32'h0, 2));
    q.push_back(mk(1, BASE + 32'h10, 3'b000, 32'hBAD0_0003, 2));
    q.push_back(mk(0, BASE + 32'h10, 3'b000, 32'h0, 2));
    q.push_back(mk(0, BASE + 32'h10, 3'b010, 32'h0, 2));
    x = mk(0, BASE - 32'h4, 3'b010, 32'h0, 2);
    q.push_back(x);
    run_seq();
  endtask

  task automatic random_set(input int n);
    xfer_t x;
    int r;
    for (int i = 0; i < n; i++) begin
      x = mk($urandom_range(0, 1), 32'h0, 3'b010, $urandom,
             (i == 0 || $urandom_range(0, 1) == 0) ? 2'd2 : 2'd3);
      x.burst = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0)
        x.addr = BASE + 4 * $urandom_range(0, 3);
      else
        x.addr = BASE + 4 * $urandom_range(0, DEPTH - 1);
      r = $urandom_range(0, 19);
      case (r)
        0: x.tr = 2'd0;
        1: x.sel = 1'b0;
        2: x.addr = BASE + 4 * DEPTH + 4 * $urandom_range(0, 15);
        3: x.addr[1:0] = 2'($urandom_range(1, 3));
        4: x.size = 3'($urandom_range(0, 1));
        5: x.addr = BASE - 4 * $urandom_range(1, 8);
        6: x.tr = 2'd1;
        default: ;
      endcase
      q.push_back(x);
    end
    run_seq();
  endtask

  initial begin
    xfer_t x;
    // Reset with a NONSEQ request present on the WAIT_STATES=3 slave.
    g_dut = 1'b1;
    m_sel = 1'b1;
    m_trans = 2'd2;
    m_addr = BASE;
    repeat (3) begin
      @(negedge HCLK);
      check("rst_hready", w_rdy, 1);
      check("rst_hresp", w_rsp, 0);
      check("rst_hrdata", w_rd, 0);
    end
    @(posedge HCLK);
    #1;
    HRESET = 1'b1;
    drive_idle();
    @(negedge HCLK);
    check("rst_noaccept", w_rdy, 1);
    @(posedge HCLK);
    #1;

    // Fill both memories so every later read has a known value.
    for (int d = 0; d < 2; d++) begin
      g_dut = d[0];
      for (int i = 0; i < DEPTH; i++)
        q.push_back(mk(1, BASE + 4 * i, 3'b010, $urandom,
                       (i == 0) ? 2'd2 : 2'd3));
      run_seq();
    end

    // Write then read back-to-back: read forwards the completing write.
    g_dut = 1'b0;
    q.push_back(mk(1, BASE + 32'h10, 3'b010, 32'hDEAD_BEEF, 2));
    q.push_back(mk(0, BASE + 32'h10, 3'b010, 32'h0, 2));
    run_seq();
    check("fwd_data", last_rd, 32'hDEAD_BEEF);
    check("fwd_lat", last_dc, 1);

    // Three wait states on the second slave.
    g_dut = 1'b1;
    q.push_back(mk(1, BASE + 32'h20, 3'b010, 32'h1234_5678, 2));
    run_seq();
    lo_cnt = 0;
    q.push_back(mk(0, BASE + 32'h20, 3'b010, 32'h0, 2));
    run_seq();
    check("ws3_low", lo_cnt, 3);
    check("ws3_lat", last_dc, 4);
    check("ws3_data", last_rd, 32'h1234_5678);

    // INCR4 write burst then INCR4 read burst with no stalls.
    g_dut = 1'b0;
    lo_cnt = 0;
    rd_log.delete();
    for (int i = 0; i < 8; i++) begin
      x = mk(i < 4, BASE + 32'h40 + 4 * (i % 4), 3'b010,
             32'(i % 4 + 1), (i % 4 == 0) ? 2'd2 : 2'd3);
      x.burst = 3'b011;
      q.push_back(x);
    end
    run_seq();
    check("burst_stall", lo_cnt, 0);
    check("burst_nrd", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++)
      check("burst_rd", rd_log[i], 32'(i + 1));

    // Illegal accesses on both slaves.
    for (int d = 0; d < 2; d++) begin
      g_dut = d[0];
      illegal_set();
      check("ill_resp", last_rsp, ERR_EN ? 1 : 0);
      check("ill_rdata", last_rd, 32'h0);
    end

    // Reset while a write waits on the WAIT_STATES=3 slave.
    g_dut = 1'b1;
    q.push_back(mk(1, BASE + 32'h08, 3'b010, 32'hAAAA_AAAA, 2));
    run_seq();
    m_sel = 1'b1;
    m_trans = 2'd2;
    m_wr = 1'b1;
    m_addr = BASE + 32'h08;
    m_size = 3'b010;
    @(negedge HCLK);
    check("mid_accept", w_rdy, 1);
    @(posedge HCLK);
    #1;
    drive_idle();
    m_wdata = 32'h5555_5555;
    @(negedge HCLK);
    check("mid_wait", w_rdy, 0);
    HRESET = 1'b0;
    @(posedge HCLK);
    #1;
    HRESET = 1'b1;
    @(negedge HCLK);
    check("mid_hready", w_rdy, 1);
    check("mid_hresp", w_rsp, 0);
    check("mid_hrdata", w_rd, 0);
    @(posedge HCLK);
    #1;
    q.push_back(mk(0, BASE + 32'h08, 3'b010, 32'h0, 2));
    run_seq();
    check("mid_keep", last_rd, 32'hAAAA_AAAA);

    // Random traffic on both slaves.
    for (int d = 0; d < 2; d++) begin
      g_dut = d[0];
      random_set(400);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_slave_ram.md
Name: ahb_slave_ram

Overview:
- AHB slave responder: the far end of the master transfers issued by the CAN transmitter's AHB master port.
- Word-wide on-chip RAM with a programmable number of wait states and a decoded address window.
- Connects to the AHBS modport of the AHB interface.
- Instantiated in the bench as the memory the transmitter's master fetches frames from and writes status to.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 16..4096.
- WAIT_STATES, 0, HREADY-low cycles inserted in every OKAY read/write data phase; 0..15.

Ports:
- HCLK  in  1  clock; all state updates on rising edge.
- HRESET  in  1  reset, synchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address (address phase).
- HWRITE  in  1  1 = write (address phase).
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HSIZE  in  3  transfer size; only 3'b010 (word) is legal.
- HBURST  in  3  burst type; sampled but not acted on (every beat carries its own address).
- HWDATA  in  32  write data (data phase).
- HREADY  out  1  transfer-complete / address-accept.
- HRESP  out  2  OKAY=0, ERROR=1.
- HRDATA  out  32  read data; valid only when HREADY=1 in a read data phase.

Behaviour:
- Reset: on any edge with HRESET=0, state goes to IDLE and outputs are HREADY=1, HRESP=OKAY, HRDATA=0. Any pending write is discarded. RAM contents are not reset. Reset is honoured mid-wait and mid-error.
- Address sampling: address phase is accepted on an edge where HSEL=1, HREADY=1 (own output) and HTRANS[1]=1. Captured: address, write, size.
- Ignored phases: IDLE/BUSY or HSEL=0 with HREADY=1 give a zero-wait OKAY and no access.
- Legal transfer: HSIZE=word, HADDR[1:0]=0, and BASE_ADDR <= HADDR < BASE_ADDR+4*DEPTH_WORDS. Word index = (HADDR-BASE_ADDR)>>2.
- States:
  - IDLE: no data phase pending; HREADY=1, HRESP=OKAY.
  - WAIT: counter loaded with WAIT_STATES-1 on accept; HREADY=0 while counting; goes to DATA when counter = 0. Skipped if WAIT_STATES=0.
  - DATA: HREADY=1, HRESP=OKAY; the transfer completes at the end of this cycle.
  - ERR1: HREADY=0, HRESP=ERROR.
  - ERR2: HREADY=1, HRESP=ERROR.
- Transitions:
  - Accepting a legal transfer goes to WAIT or DATA.
  - Accepting an illegal transfer goes to ERR1, then ERR2. No wait states are inserted on errors.
  - Leaving DATA or ERR2: a new transfer sampled on that edge chains directly; otherwise return to IDLE.
- Latency: a read completes WAIT_STATES+1 cycles after its address-accept edge. HRDATA is registered so it is valid throughout the completing DATA cycle; it is held otherwise.
- Writes: HWDATA is sampled on the edge ending DATA and written to RAM on that edge.
- Read-after-write hazard: if a read is accepted on the same edge a write completes, to the same index, HRDATA must return the new HWDATA (forward it, not the stale RAM word).
- Pipelining: back-to-back NONSEQ/SEQ with WAIT_STATES=0 sustain one word per cycle.
- Illegal-transfer side effects: illegal writes never modify RAM; illegal reads drive HRDATA=0.

Optional Feature:
- Macro: AHB_SLV_ERROR_EN.
- Defined: illegal transfers take the two-cycle ERROR response described above.
- Undefined:
  - Illegal transfers follow the normal OKAY path, including wait states.
  - Writes are dropped and reads return 32'h0.
  - The ERR1/ERR2 states are not built.

Decomposition:
- Shared package ahb_pkg:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ).
  - hresp_t enum (OKAY, ERROR, RETRY, SPLIT).
  - HSIZE_WORD constant.
  - slave state enum (IDLE, WAIT, DATA, ERR1, ERR2).
- Sub-module ahb_ram_array: DEPTH_WORDS x 32, one synchronous write port, one registered read port, no reset.
- The FSM, decode and forwarding logic stay in ahb_slave_ram.

Test Plan:
- Reset: hold HRESET=0 for 3 cycles, with HTRANS=NONSEQ on an edge while HRESET=0 -> HREADY=1, HRESP=0, HRDATA=0; no transfer accepted.
- Single write then read, WAIT_STATES=0:
  - Write 32'hDEAD_BEEF to BASE+0x10; next address phase reads 0x10.
  - Read completes 1 cycle after accept with HRDATA=32'hDEAD_BEEF (forwarding path exercised).
- WAIT_STATES=3, read of 0x20 previously loaded with 32'h1234_5678 -> HREADY low for exactly 3 cycles, then high with HRDATA=32'h1234_5678.
- INCR4 burst:
  - 4 writes of 1,2,3,4 to 0x40..0x4C, then 4 reads with WAIT_STATES=0.
  - 8 consecutive HREADY=1 cycles; reads return 1,2,3,4.
- Out-of-range and misaligned accesses:
  - Targets: BASE+4*DEPTH_WORDS, HADDR=BASE+0x2, and HSIZE=byte.
  - With AHB_SLV_ERROR_EN: each gives HREADY 0 then 1 with HRESP=1 on both cycles, and RAM is unchanged.
  - Without the macro: each gives OKAY and reads return 0.
- Reset mid-operation:
  - HRESET=0 while in WAIT with a write pending to 0x08 (old value 32'hAAAA_AAAA).
  - Next cycle: HREADY=1, state IDLE.
  - A later read of 0x08 returns 32'hAAAA_AAAA.
